layer1_pool_window_sched: RTL and testbench

//  Scan controller for the layer-1 mid channel buffer (32 channels, 34x26 map each).

---
 rtl/layer1_pool_window_sched.sv | 154 +++++++++++++++
 tb/tb_layer1_pool_window_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/layer1_pool_window_sched.sv
// layer1_pool_window_sched: raster scan of 2x2 window origins over the
// layer-1 mid channel buffer, one origin per valid/ready transfer.
// Ports: clk, rst (sync, active-high), start, abort, buf_ready, win_ready;
//        win_valid, win_row[5:0], win_col[4:0], win_cnt, busy, done,
//        stall_cnt (only when SCHED_STALL_CNT_EN is defined).
// Optional macro: SCHED_STALL_CNT_EN adds the stall_cnt counter and port.
module layer1_pool_window_sched #(
    parameter int ROWS   = 34,
    parameter int COLS   = 26,
    parameter int WIN    = 2,
    parameter int STRIDE = 2,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             buf_ready,
    input  logic             win_ready,
    output logic             win_valid,
    output logic [5:0]       win_row,
    output logic [4:0]       win_col,
    output logic [CNT_W-1:0] win_cnt,
    output logic             busy,
    output logic             done
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Last origin on the stride grid; leftover rows/cols are never visited.
    localparam int NR = (ROWS - WIN) / STRIDE + 1;
    localparam int NC = (COLS - WIN) / STRIDE + 1;
    localparam logic [5:0] R_LAST = 6'((NR - 1) * STRIDE);
    localparam logic [4:0] C_LAST = 5'((NC - 1) * STRIDE);
    localparam logic [5:0] R_STEP = 6'(STRIDE);
    localparam logic [4:0] C_STEP = 5'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SCAN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       row_q, row_d;
    logic [4:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;
    logic             last;

    assign xfer = win_valid & win_ready;
    assign last = (row_q == R_LAST) && (col_q == C_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks every transfer, including the last.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_WAIT;
            S_WAIT: begin
                if (abort)          state_d = S_IDLE;
                else if (buf_ready) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (abort)              state_d = S_IDLE;
                else if (xfer && last)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; win_valid is gated by buf_ready so a buffer drop pauses
    // the scan without moving the origin.
    always_comb begin
        win_valid = (state_q == S_SCAN) && buf_ready;
        busy      = (state_q == S_WAIT) || (state_q == S_SCAN);
        done      = (state_q == S_DONE);
    end

    assign win_row = row_q;
    assign win_col = col_q;
    assign win_cnt = cnt_q;

    // Origin and window counter
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (state_q == S_IDLE && start) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
        end else if (state_q == S_SCAN && !abort && xfer) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (!last) begin
                if (col_q == C_LAST) begin
                    col_d = '0;
                    row_d = row_q + R_STEP;
                end else begin
                    col_d = col_q + C_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == S_SCAN && win_valid && !win_ready &&
                     stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_layer1_pool_window_sched.sv
// Directed bench for layer1_pool_window_sched: default 34x26 grid plus a
// 5x7 override instance, checked with immediate assertions.
module tb_layer1_pool_window_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        buf_ready = 1'b0;
    logic        win_ready = 1'b0;
    logic        win_valid, busy, done;
    logic [5:0]  win_row;
    logic [4:0]  win_col;
    logic [10:0] win_cnt;

    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic        win_valid2, busy2, done2;
    logic [5:0]  win_row2;
    logic [4:0]  win_col2;
    logic [10:0] win_cnt2;

`ifdef SCHED_STALL_CNT_EN
    logic [10:0] stall_cnt, stall_cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int er[6] = '{0, 0, 0, 2, 2, 2};
    int ec[6] = '{0, 2, 4, 0, 2, 4};

    always #5 clk = ~clk;

    layer1_pool_window_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .buf_ready(buf_ready), .win_ready(win_ready),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .win_cnt(win_cnt), .busy(busy), .done(done)
`ifdef SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    layer1_pool_window_sched #(.ROWS(5), .COLS(7)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .buf_ready(buf_ready), .win_ready(win_ready),
        .win_valid(win_valid2), .win_row(win_row2), .win_col(win_col2),
        .win_cnt(win_cnt2), .busy(busy2), .done(done2)
`ifdef SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs sampled 2 later.
    task automatic run_scan(input int pat, input int drop_k,
                            input int abort_k);
        int k = 0;
        int r = 0;
        int c = 0;
        int drops = 0;
        int cyc = 0;
        bit ph = 1'b0;
        bit drop, rdy, ab;
        @(posedge clk); #1;
        start = 1'b1; buf_ready = 1'b1; win_ready = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        #2;
        chk("wait_busy", 32'(busy), 1);
        chk("wait_valid", 32'(win_valid), 0);
        chk("start_cnt_clr", 32'(win_cnt), 0);
        while (k < 221 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            drop = (k == drop_k) && (drops < 5);
            if (drop) drops++;
            rdy = (pat == 0) ? 1'b1 : ph;
            ab = (k == abort_k) && rdy && !drop;
            buf_ready = !drop;
            win_ready = rdy;
            abort = ab;
            #2;
            chk("valid", 32'(win_valid), 32'(!drop));
            chk("row", 32'(win_row), 32'(r));
            chk("col", 32'(win_col), 32'(c));
            chk("cnt", 32'(win_cnt), 32'(k));
            if (ab) begin
                @(posedge clk); #1;
                abort = 1'b0; win_ready = 1'b0;
                #2;
                chk("abort_valid", 32'(win_valid), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_cnt", 32'(win_cnt), 32'(k));
                @(posedge clk); #3;
                chk("abort_nodone", 32'(done), 0);
                return;
            end
            if (!drop) begin
                ph = !ph;
                if (rdy) begin
                    k++;
                    c += 2;
                    if (c > 24) begin
                        c = 0;
                        r += 2;
                    end
                end
            end
        end
        if (k < 221) chk("timeout", 32'(k), 221);
        @(posedge clk); #1;
        win_ready = 1'b0;
        #2;
        chk("done_pulse", 32'(done), 1);
        chk("done_valid", 32'(win_valid), 0);
        chk("done_cnt", 32'(win_cnt), 221);
        chk("done_busy", 32'(busy), 0);
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), (pat == 1) ? 221 : 0);
`endif
        @(posedge clk); #3;
        chk("done_once", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("cnt_hold", 32'(win_cnt), 221);
    endtask

    initial begin
        // T1: reset values, then a full-rate scan
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_valid", 32'(win_valid), 0);
        chk("rst_row", 32'(win_row), 0);
        chk("rst_col", 32'(win_col), 0);
        chk("rst_cnt", 32'(win_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        run_scan(0, -1, -1);

        // T2: ready alternates 0,1 so each origin is held two cycles
        run_scan(1, -1, -1);

        // T3: buffer drops for 5 cycles at origin (4,6), index 29
        run_scan(0, 29, -1);

        // T4: abort on the 100th transfer, then a clean restart
        run_scan(0, -1, 99);
        run_scan(0, -1, -1);

        // T5: 5x7 map gives a 2x3 origin grid
        @(posedge clk); #1;
        start2 = 1'b1; buf_ready = 1'b1; win_ready = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        #2;
        chk("s_busy", 32'(busy2), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #3;
            chk("s_valid", 32'(win_valid2), 1);
            chk("s_row", 32'(win_row2), 32'(er[i]));
            chk("s_col", 32'(win_col2), 32'(ec[i]));
            chk("s_cnt", 32'(win_cnt2), 32'(i));
        end
        @(posedge clk); #3;
        chk("s_done", 32'(done2), 1);
        chk("s_cnt_end", 32'(win_cnt2), 6);
        chk("s_valid_end", 32'(win_valid2), 0);

        // T6: rst mid-scan with start held high
        @(posedge clk); #1;
        start = 1'b1; buf_ready = 1'b1; win_ready = 1'b1;
        @(posedge clk); #3;
        chk("t6_busy", 32'(busy), 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #3;
            chk("t6_cnt", 32'(win_cnt), 32'(i));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #3;
        chk("t6_rst_valid", 32'(win_valid), 0);
        chk("t6_rst_row", 32'(win_row), 0);
        chk("t6_rst_col", 32'(win_col), 0);
        chk("t6_rst_cnt", 32'(win_cnt), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
`ifdef SCHED_STALL_CNT_EN
        chk("t6_rst_stall", 32'(stall_cnt), 0);
`endif
        rst = 1'b0;
        @(posedge clk); #3;
        chk("t6_restart_busy", 32'(busy), 1);
        chk("t6_restart_wait", 32'(win_valid), 0);
        @(posedge clk); #3;
        chk("t6_restart_valid", 32'(win_valid), 1);
        chk("t6_restart_row", 32'(win_row), 0);
        chk("t6_restart_col", 32'(win_col), 0);
        chk("t6_restart_cnt", 32'(win_cnt), 0);
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
